// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; bytes written by the core are
// queued and shifted out LSB first, with back-to-back frames kept contiguous.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  DEPTH_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LOAD   = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [1:0]        state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic              baud_done;
    logic              pop;
    logic              push;

    assign full      = (count == DEPTH_COUNT);
    assign empty     = (count == '0);
    assign busy      = (state != IDLE) || !empty;
    assign baud_done = (baud == '0);

    // A pop frees a slot on the same edge, so a write while full still lands.
    assign pop  = !empty && ((state == IDLE) || ((state == STOP) && baud_done));
    assign push = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_en && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // tx is registered from the next-state decision, so it changes on the
    // same edge as the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                        baud  <= BAUD_LOAD;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        baud    <= BAUD_LOAD;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud - BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud - BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= BAUD_LOAD;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud - BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scenario bench for uart_tx_fifo: a queue/frame-position reference model plus
// an independent serial decoder on tx.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int D     = 4;
    localparam int FRAME = 10 * C;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       tx;
    logic [4:0] obs;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    assign obs = {tx, busy, empty, full, overflow};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: byte queue plus position within the current frame (-1 = idle).
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_cur = 8'h00;
    int         m_pos = -1;
    logic       m_ovf = 1'b0;

    task automatic model_reset();
        m_q.delete();
        m_pos = -1;
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic wr, input logic [7:0] d);
        logic can_pop;
        logic was_full;
        can_pop  = ((m_pos < 0) || (m_pos == FRAME - 1)) && (m_q.size() > 0);
        was_full = (m_q.size() == D);
        if (can_pop) begin
            m_cur = m_q.pop_front();
            m_sent.push_back(m_cur);
            m_pos = 0;
        end else if (m_pos == FRAME - 1) begin
            m_pos = -1;
        end else if (m_pos >= 0) begin
            m_pos++;
        end
        if (wr) begin
            if (!was_full || can_pop) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic [4:0] model_out();
        logic t;
        int   b;
        if (m_pos < 0) begin
            t = 1'b1;
        end else begin
            b = m_pos / C;
            if (b == 0) t = 1'b0;
            else if (b == 9) t = 1'b1;
            else t = m_cur[b-1];
        end
        return {t, (m_pos >= 0) || (m_q.size() != 0), m_q.size() == 0, m_q.size() == D, m_ovf};
    endfunction

    // Serial decoder: samples mid-bit on falling edges, independent of the model.
    int         rx_pos  = -1;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];
    int         rx_start[$];

    always @(negedge clk) begin
        if (!reset) begin
            rx_pos <= -1;
        end else if (rx_pos < 0) begin
            if (tx === 1'b0) begin
                rx_pos <= 1;
                rx_start.push_back(cyc);
            end
        end else begin
            if ((rx_pos % C == C / 2) && (rx_pos / C >= 1) && (rx_pos / C <= 8))
                rx_byte[rx_pos / C - 1] <= tx;
            if (rx_pos == FRAME - 1) begin
                rx_q.push_back(rx_byte);
                rx_pos <= -1;
            end else begin
                rx_pos <= rx_pos + 1;
            end
        end
    end

    task automatic tick(input logic wr, input logic [7:0] d);
        wr_en   = wr;
        wr_data = d;
        @(posedge clk);
        model_edge(wr, d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_start.delete();
        m_sent.delete();
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (obs !== 5'b10100) begin
            mismatched++;
            $display("[TB] FAIL reset_state got=%b exp=%b", obs, 5'b10100);
        end
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [4:0] e;
        logic       bit_exp;
        clear_rx();
        tick(1'b1, 8'h55);
        compared++;
        if (empty !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL first_write_accept got=%b exp=0", empty);
        end
        for (int i = 0; i < 45; i++) begin
            tick(1'b0, 8'h00);
            e = model_out();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL single_cycle cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
            bit_exp = (i < FRAME) ? ((i / C) % 2 == 1) : 1'b1;
            compared++;
            if (tx !== bit_exp) begin
                mismatched++;
                $display("[TB] FAIL single_0x55_bit i=%0d got=%b exp=%b", i, tx, bit_exp);
            end
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_busy_end got=%b exp=0", busy);
        end
        compared++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
            mismatched++;
            $display("[TB] FAIL single_decode got_n=%0d exp_n=1 exp=55", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        clear_rx();
        tick(1'b1, 8'hA5);
        tick(1'b1, 8'h3C);
        for (int i = 0; i < 90; i++) begin
            tick(1'b0, 8'h00);
            e = model_out();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL b2b_cycle cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        compared++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin
            mismatched++;
            $display("[TB] FAIL b2b_decode got_n=%0d exp_n=2 exp=a5,3c", rx_q.size());
        end
        compared++;
        if (rx_start.size() != 2 || (rx_start[1] - rx_start[0]) != FRAME) begin
            mismatched++;
            $display("[TB] FAIL b2b_gap got_starts=%0d exp_spacing=%0d", rx_start.size(), FRAME);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] e;
        logic [7:0] v;
        clear_rx();
        for (int i = 1; i <= 6; i++) begin
            v = 8'(i);
            tick(1'b1, v);
            e = model_out();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL ovf_write cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
            if (i == 5) begin
                compared++;
                if (full !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL ovf_full_after_5 got=%b exp=1", full);
                end
            end
        end
        compared++;
        if (overflow !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovf_flag got=%b exp=1", overflow);
        end
        for (int i = 0; i < 210; i++) begin
            tick(1'b0, 8'h00);
            e = model_out();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL ovf_drain cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        compared++;
        if (rx_q.size() != 5) begin
            mismatched++;
            $display("[TB] FAIL ovf_count got=%0d exp=5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                compared++;
                if (rx_q[i] !== 8'(i + 1)) begin
                    mismatched++;
                    $display("[TB] FAIL ovf_order idx=%0d got=%h exp=%h", i, rx_q[i], 8'(i + 1));
                end
            end
        end
        compared++;
        if (overflow !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovf_sticky got=%b exp=1", overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [4:0] e;
        logic [7:0] seq [6];
        int guard;
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};
        do_reset();
        clear_rx();
        for (int i = 0; i < 5; i++) tick(1'b1, seq[i]);
        compared++;
        if (full !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL fullpop_full got=%b exp=1", full);
        end
        guard = 0;
        while (m_pos != FRAME - 1 && guard < 100) begin
            tick(1'b0, 8'h00);
            guard++;
        end
        tick(1'b1, 8'h77);
        compared++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fullpop_accept got_full=%b got_ovf=%b exp=1,0", full, overflow);
        end
        for (int i = 0; i < 210; i++) begin
            tick(1'b0, 8'h00);
            e = model_out();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL fullpop_cycle cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        compared++;
        if (rx_q.size() != 6) begin
            mismatched++;
            $display("[TB] FAIL fullpop_count got=%0d exp=6", rx_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                compared++;
                if (rx_q[i] !== seq[i]) begin
                    mismatched++;
                    $display("[TB] FAIL fullpop_order idx=%0d got=%h exp=%h", i, rx_q[i], seq[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] e;
        int guard;
        do_reset();
        clear_rx();
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'h12);
        tick(1'b1, 8'h34);
        guard = 0;
        while (m_pos != 4 * C && guard < 100) begin
            tick(1'b0, 8'h00);
            guard++;
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (obs !== 5'b10100) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_async got=%b exp=%b", obs, 5'b10100);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rx_q.delete();
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 8'h00);
            e = model_out();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL reset_mid_after cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        compared++;
        if (rx_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_no_frame got=%0d exp=0", rx_q.size());
        end
    endtask

    task automatic test_idle_toggle();
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, (i % 2 == 0) ? 8'hAA : 8'h55);
            compared++;
            if (obs !== 5'b10100) begin
                mismatched++;
                $display("[TB] FAIL idle_toggle cyc=%0d got=%b exp=%b", cyc, obs, 5'b10100);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] e;
        int rate;
        logic wr;
        clear_rx();
        rate = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) rate = $urandom_range(0, 6);
            wr = ($urandom_range(0, 39) < rate);
            tick(wr, 8'($urandom));
            e = model_out();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL random_cycle cyc=%0d got=%b exp=%b", cyc, obs, e);
            end
        end
        for (int i = 0; i < 250; i++) tick(1'b0, 8'h00);
        compared++;
        if (rx_q.size() != m_sent.size()) begin
            mismatched++;
            $display("[TB] FAIL random_count got=%0d exp=%0d", rx_q.size(), m_sent.size());
        end else begin
            for (int i = 0; i < rx_q.size(); i++) begin
                compared++;
                if (rx_q[i] !== m_sent[i]) begin
                    mismatched++;
                    $display("[TB] FAIL random_byte idx=%0d got=%h exp=%h", i, rx_q[i], m_sent[i]);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_idle_toggle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
